// File: rtl/or_pkg.sv
// Shared definitions for the or_accum_array block: lane operation modes and
// the lane slicing helper used wherever packed lane buses are split.
package or_pkg;

   typedef enum logic [1:0] {
      MODE_OR     = 2'b00,
      MODE_NOR    = 2'b01,
      MODE_STICKY = 2'b10,
      MODE_RDCLR  = 2'b11
   } mode_e;

   // LSB position of lane k in a bus packed as lane k at [k*width +: width].
   function automatic int lane_lo(input int k, input int width);
      return k * width;
   endfunction

endpackage

// File: rtl/or_lane.sv
// One lane of or_accum_array: OR/NOR combine of a and b, plus the sticky
// accumulator register that STICKY and STICKY_RDCLR operate on.
module or_lane
   import or_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             accept,
   input  logic [1:0]       mode,
   input  logic             clr,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] acc
);

   mode_e            mode_q;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] acc_eff;
   logic [WIDTH-1:0] acc_nxt;

   assign mode_q = mode_e'(mode);
   assign e      = a | b;
   // A same-cycle clr makes the accumulator read as zero for this transfer.
   assign acc_eff = clr ? '0 : acc;

   always_comb begin
      res     = e;
      acc_nxt = acc_eff;
      case (mode_q)
         MODE_OR:  res = e;
         MODE_NOR: res = ~e;
         MODE_STICKY: begin
            res = acc_eff | e;
            if (accept) acc_nxt = acc_eff | e;
         end
         MODE_RDCLR: begin
            res = acc_eff | e;
            if (accept) acc_nxt = '0;
         end
         default: res = e;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= '0;
      else        acc <= acc_nxt;
   end

endmodule

// File: rtl/or_accum_array.sv
// CHANNELS lanes of OR/NOR/sticky-OR behind one registered valid/ready output
// stage, with a saturating count of accepted transfers that produced a set bit.
module or_accum_array
   import or_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                mode,
   input  logic [CHANNELS*WIDTH-1:0] a,
   input  logic [CHANNELS*WIDTH-1:0] b,
   input  logic                      clr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS*WIDTH-1:0] c,
   output logic [CHANNELS-1:0]       any,
   output logic [CNT_W-1:0]          hit_cnt
);

   localparam int W = CHANNELS * WIDTH;

   logic             accept;
   logic [W-1:0]     res_all;
   logic [W-1:0]     unused_acc;
   logic [CHANNELS-1:0] any_nxt;
   logic [CNT_W-1:0] hit_base;
   logic [CNT_W-1:0] hit_nxt;

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; the output register may be refilled in the same cycle it drains.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      or_lane #(.WIDTH(WIDTH)) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .accept (accept),
         .mode   (mode),
         .clr    (clr),
         .a      (a[lane_lo(k, WIDTH) +: WIDTH]),
         .b      (b[lane_lo(k, WIDTH) +: WIDTH]),
         .res    (res_all[lane_lo(k, WIDTH) +: WIDTH]),
         .acc    (unused_acc[lane_lo(k, WIDTH) +: WIDTH])
      );
      assign any_nxt[k] = |res_all[lane_lo(k, WIDTH) +: WIDTH];
   end

   // clr restarts the count, so a same-cycle non-zero accept lands on 1.
   assign hit_base = clr ? '0 : hit_cnt;
   assign hit_nxt  = (accept && (|res_all) && (hit_base != {CNT_W{1'b1}}))
                     ? hit_base + CNT_W'(1) : hit_base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         c         <= '0;
         any       <= '0;
         hit_cnt   <= '0;
      end else begin
         hit_cnt <= hit_nxt;
         if (accept) begin
            out_valid <= 1'b1;
            c         <= res_all;
            any       <= any_nxt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_or_accum_array.sv
// Self-checking bench for or_accum_array: vector table plus hand sequences,
// with an expected-result queue drained on each output transfer.
module tb_or_accum_array;
   import or_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, clr, out_valid, out_ready;
   logic [1:0]  mode;
   logic [31:0] a, b, c;
   logic [3:0]  any;
   logic [15:0] hit_cnt;

   logic        in_valid2, in_ready2, clr2, out_valid2, out_ready2;
   logic [1:0]  mode2;
   logic [31:0] a2, b2, c2;
   logic [3:0]  any2;
   logic [1:0]  hit_cnt2;

   int checks = 0;
   int failures = 0;
   logic [35:0] exp_q[$];
   logic [35:0] dummy;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_c;
      logic [3:0]  exp_any;
      logic [15:0] exp_hit;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   or_accum_array u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .a(a), .b(b), .clr(clr), .out_valid(out_valid),
      .out_ready(out_ready), .c(c), .any(any), .hit_cnt(hit_cnt)
   );

   or_accum_array #(.WIDTH(8), .CHANNELS(4), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .mode(mode2), .a(a2), .b(b2), .clr(clr2), .out_valid(out_valid2),
      .out_ready(out_ready2), .c(c2), .any(any2), .hit_cnt(hit_cnt2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Called just after a falling edge with inputs already set; returns on the
   // next falling edge. Compares the pending output, then records new accepts.
   task automatic cycle(input logic [35:0] exp);
      #1;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual_c=%0h expected=none", c);
         end else begin
            chk("sb_c", 64'(c), 64'(exp_q[0][35:4]));
            chk("sb_any", 64'(any), 64'(exp_q[0][3:0]));
            if (out_ready) dummy = exp_q.pop_front();
         end
      end
      if (in_valid && in_ready) exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{MODE_OR,     32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0001, 16'd1};
      vecs[1] = '{MODE_NOR,    32'h00000001, 32'h00000002, 32'hFFFFFFFC, 4'b1111, 16'd2};
      vecs[2] = '{MODE_STICKY, 32'h00000001, 32'h00000000, 32'h00000001, 4'b0001, 16'd3};
      vecs[3] = '{MODE_STICKY, 32'h00000002, 32'h00000000, 32'h00000003, 4'b0001, 16'd4};
      vecs[4] = '{MODE_STICKY, 32'h00000000, 32'h00000080, 32'h00000083, 4'b0001, 16'd5};
      vecs[5] = '{MODE_RDCLR,  32'h00000000, 32'h00000000, 32'h00000083, 4'b0001, 16'd6};
      vecs[6] = '{MODE_STICKY, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0000, 16'd6};
      vecs[7] = '{MODE_OR,     32'hA0000000, 32'h05000000, 32'hA5000000, 4'b1000, 16'd7};

      rst_n = 1'b0;
      in_valid = 0; mode = MODE_OR; a = '0; b = '0; clr = 0; out_ready = 1;
      in_valid2 = 0; mode2 = MODE_OR; a2 = '0; b2 = '0; clr2 = 0; out_ready2 = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_c", 64'(c), 64'h0);
      chk("rst_any", 64'(any), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_hit", 64'(hit_cnt), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);

      // Table vectors, back to back with the consumer always ready.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; mode = vecs[i].mode; a = vecs[i].a; b = vecs[i].b;
         cycle({vecs[i].exp_c, vecs[i].exp_any});
         chk("vec_hit", 64'(hit_cnt), 64'(vecs[i].exp_hit));
         chk("vec_out_valid", 64'(out_valid), 64'h1);
      end
      in_valid = 0;
      cycle('0);
      chk("drain_out_valid", 64'(out_valid), 64'h0);

      // Backpressure: result must hold while the consumer stalls.
      out_ready = 0; in_valid = 1; mode = MODE_OR; a = 32'h11; b = '0;
      cycle({32'h11, 4'b0001});
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", 64'(in_ready), 64'h0);
         chk("stall_out_valid", 64'(out_valid), 64'h1);
         a = $urandom_range(32'hFFFF, 32'h100);
         cycle('0);
      end
      out_ready = 1; a = 32'h22;
      cycle({32'h22, 4'b0001});
      chk("bp_out_valid_kept", 64'(out_valid), 64'h1);
      chk("bp_hit", 64'(hit_cnt), 64'd9);
      in_valid = 0;
      cycle('0);

      // clr together with a STICKY accept.
      in_valid = 1; mode = MODE_STICKY; a = 32'hF0;
      cycle({32'hF0, 4'b0001});
      chk("acc_load_hit", 64'(hit_cnt), 64'd10);
      clr = 1; a = 32'h01;
      cycle({32'h01, 4'b0001});
      chk("clr_accept_hit", 64'(hit_cnt), 64'd1);
      clr = 0; a = '0;
      cycle({32'h01, 4'b0001});
      chk("clr_acc_kept_e_hit", 64'(hit_cnt), 64'd2);
      in_valid = 0; clr = 1;
      cycle('0);
      chk("clr_alone_hit", 64'(hit_cnt), 64'd0);
      clr = 0; in_valid = 1; mode = MODE_STICKY; a = '0;
      cycle({32'h0, 4'b0000});
      chk("clr_alone_hit2", 64'(hit_cnt), 64'd0);

      // Inputs presented without in_valid must be ignored.
      in_valid = 0; mode = MODE_OR; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      cycle('0);
      cycle('0);
      chk("idle_out_valid", 64'(out_valid), 64'h0);
      chk("idle_hit", 64'(hit_cnt), 64'd0);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      // Two-bit counter saturates at 3.
      in_valid2 = 1; mode2 = MODE_OR; a2 = 32'h1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("sat_hit", 64'(hit_cnt2), (i < 3) ? 64'(i + 1) : 64'd3);
         chk("sat_c", 64'(c2), 64'h1);
      end
      in_valid2 = 0; out_ready2 = 0;
      in_valid = 1; out_ready = 0; a = 32'h5; b = '0;
      cycle({32'h5, 4'b0001});
      chk("pre_rst_valid", 64'(out_valid), 64'h1);
      chk("pre_rst_valid2", 64'(out_valid2), 64'h1);

      // Asynchronous reset mid-cycle, checked before the next rising edge.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_c", 64'(c), 64'h0);
      chk("arst_any", 64'(any), 64'h0);
      chk("arst_out_valid", 64'(out_valid), 64'h0);
      chk("arst_hit", 64'(hit_cnt), 64'h0);
      chk("arst_c2", 64'(c2), 64'h0);
      chk("arst_out_valid2", 64'(out_valid2), 64'h0);
      chk("arst_hit2", 64'(hit_cnt2), 64'h0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 0; in_valid2 = 0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/or_accum_array.md
Name: or_accum_array

Overview:
- Parametrised, registered successor to the two-input OR cell.
- CHANNELS independent lanes, each WIDTH bits wide.
- Each lane computes OR, NOR, or a sticky OR-accumulate of operands a and b.
- Results leave through one valid/ready output register. A saturating hit counter tracks non-zero results.
- Sits between flag-producing datapath blocks and status/interrupt logic.

Parameters:
WIDTH, 8, bits per lane operand and result
CHANNELS, 4, number of independent lanes
CNT_W, 16, width of saturating hit counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transfer request
in_ready  output  1  block can accept input this cycle
mode  input  2  operation select: 00 OR, 01 NOR, 10 STICKY, 11 STICKY_RDCLR
a  input  CHANNELS*WIDTH  operand A, lane k at bits [k*WIDTH +: WIDTH]
b  input  CHANNELS*WIDTH  operand B, same packing
clr  input  1  synchronous clear of accumulators and hit counter
out_valid  output  1  c/any hold an unconsumed result
out_ready  input  1  consumer accepts result
c  output  CHANNELS*WIDTH  registered result, same packing
any  output  CHANNELS  registered per-lane reduction OR of c
hit_cnt  output  CNT_W  count of accepted transfers with non-zero result, saturating

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: c=0, any=0, out_valid=0, hit_cnt=0, all lane accumulators acc=0.
  - in_ready is 1 after reset, because it is combinational: in_ready = !out_valid || out_ready.
- Accept: in_valid && in_ready on a rising edge. Latency is 1 cycle: the result appears in c/any with out_valid=1 the cycle after acceptance.
- out_valid:
  - set on accept;
  - cleared when out_ready && out_valid && no accept;
  - stays 1 on simultaneous consume and accept, and c updates back-to-back for full throughput.
- While out_valid && !out_ready, c, any and out_valid hold stable. in_ready is 0 and inputs are ignored.
- Per-lane result on accept, with e = a_k | b_k:
  - OR: c_k = e; acc unchanged.
  - NOR: c_k = ~e; acc unchanged.
  - STICKY: c_k = acc_k | e; acc_k <= acc_k | e.
  - STICKY_RDCLR: c_k = acc_k | e; acc_k <= 0.
- any_k = |c_k, registered with c.
- clr is a synchronous clear acting on any cycle, with or without an accept.
  - acc <= 0 and hit_cnt <= 0.
  - If an accept happens in the same cycle, the result is computed with acc treated as 0, and acc <= e in STICKY, otherwise 0.
- hit_cnt:
  - +1 on each accept whose result has any bit set;
  - saturates at all-ones with no wrap;
  - clr plus a non-zero accept in the same cycle gives hit_cnt=1.
- mode, a and b are sampled only on accept. Values presented with in_valid=0 have no effect.
- Reset asserted mid-operation immediately zeroes every register, including a pending out_valid. The lost result is not replayed.

Decomposition:
- Shared package or_pkg:
  - mode enum: MODE_OR=2'b00, MODE_NOR=2'b01, MODE_STICKY=2'b10, MODE_RDCLR=2'b11;
  - helper function for lane slice indexing.
- Sub-module or_lane, instantiated CHANNELS times:
  - WIDTH-bit combine logic plus acc register;
  - inputs: accept, mode, clr, a_k, b_k;
  - outputs: next-result combinational and acc.
- The top level owns the handshake, the c/any registers and hit_cnt.

Test Plan:
- Reset, then OR mode, CHANNELS=4, WIDTH=8: lane0 a=0x0F b=0xF0, lane1 a=b=0, both cycle 0 -> cycle 1 c lane0=0xFF, lane1=0x00, any=4'b0001, out_valid=1, hit_cnt=1.
- NOR mode, lane0 a=0x01 b=0x02 -> c lane0=0xFC, any[0]=1.
- STICKY, out_ready=1: lane0 accepts 0x01, then 0x02, then 0x80 -> c lane0 = 0x01, 0x03, 0x83. Then RDCLR with 0x00 -> 0x83. Then STICKY with 0x00 -> 0x00.
- Backpressure: out_ready=0 after one accept -> in_ready=0, c stable for 5 cycles despite changing a. Raise out_ready together with in_valid -> new result next cycle, out_valid never drops.
- clr with STICKY accept, acc lane0=0xF0, e=0x01 -> c lane0=0x01, acc=0x01, hit_cnt=1.
- CNT_W=2: four non-zero accepts -> hit_cnt 1,2,3,3. Assert rst_n=0 mid-stream with out_valid=1 -> all outputs 0 asynchronously, before the next clk edge.
